// File: rtl/uart_rx_pkg.sv
// Shared UART RX definitions: counter widths, legal prescale values, mid-bit offset.
// Pure declarations; no latency and no backpressure apply.
package uart_rx_pkg;

    localparam int EDGE_W = 6;
    localparam int BIT_W  = 4;

    typedef logic [EDGE_W-1:0] edge_t;
    typedef logic [BIT_W-1:0]  bit_t;

    localparam edge_t PRESCALE_8   = 6'd8;
    localparam edge_t PRESCALE_16  = 6'd16;
    localparam edge_t PRESCALE_32  = 6'd32;
    localparam bit_t  BIT_CNT_MAX  = 4'd15;

    typedef enum logic [1:0] {
        VOTE_WAIT,
        VOTE_S0,
        VOTE_S1
    } vote_state_e;

    // The RX FSM calls this too, so its MID+3 consume point tracks the voter.
    function automatic edge_t mid_sample(input edge_t ps);
        return (ps >> 1) - edge_t'(1);
    endfunction

    function automatic edge_t legal_prescale(input edge_t p);
        case (p)
            PRESCALE_8, PRESCALE_16, PRESCALE_32: return p;
            default:                              return PRESCALE_8;
        endcase
    endfunction

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Bundle between the RX sampler (slave) and the RX control FSM / line (master).
// Plain wires; no latency and no backpressure.
interface uart_rx_sampler_if;
    import uart_rx_pkg::*;

    logic  RX_IN;
    edge_t Prescale;
    logic  enable;
    logic  data_samp_en;
    logic  RX_SYNC;
    edge_t edge_cnt;
    bit_t  bit_cnt;
    logic  sampled_bit;
    logic  sample_valid;

    modport slave (
        input  RX_IN, Prescale, enable, data_samp_en,
        output RX_SYNC, edge_cnt, bit_cnt, sampled_bit, sample_valid
    );

    modport master (
        output RX_IN, Prescale, enable, data_samp_en,
        input  RX_SYNC, edge_cnt, bit_cnt, sampled_bit, sample_valid
    );

endinterface

// File: rtl/uart_rx_sampler_edge_bit_counter.sv
// Prescale latch plus oversample edge counter and saturating bit counter.
// Registered outputs, 1-cycle update; no backpressure, runs whenever enable is high.
module edge_bit_counter
    import uart_rx_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  edge_t prescale_i,
    input  logic  enable_i,
    output edge_t edge_cnt_o,
    output bit_t  bit_cnt_o,
    output edge_t ps_o
);

    edge_t ps_q,   ps_d;
    edge_t edge_q, edge_d;
    bit_t  bit_q,  bit_d;

    always_comb begin
        ps_d   = ps_q;
        edge_d = edge_q + edge_t'(1);
        bit_d  = bit_q;
        // PS is frozen for the whole frame; a mid-frame Prescale change waits for idle.
        if (!enable_i) begin
            ps_d   = legal_prescale(prescale_i);
            edge_d = '0;
            bit_d  = '0;
        end else if (edge_q == ps_q - edge_t'(1)) begin
            edge_d = '0;
            if (bit_q != BIT_CNT_MAX) begin
                bit_d = bit_q + bit_t'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ps_q   <= PRESCALE_16;
            edge_q <= '0;
            bit_q  <= '0;
        end else begin
            ps_q   <= ps_d;
            edge_q <= edge_d;
            bit_q  <= bit_d;
        end
    end

    assign edge_cnt_o = edge_q;
    assign bit_cnt_o  = bit_q;
    assign ps_o       = ps_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// UART RX front end: line synchroniser, edge/bit counters, 3-sample majority voter.
// Line->RX_SYNC SYNC_STAGES cycles, last sample->sampled_bit 1 cycle; no backpressure.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    uart_rx_sampler_if.slave  bus
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_sync;

    edge_t edge_cnt;
    bit_t  bit_cnt;
    edge_t ps;
    edge_t mid;
    edge_t smp0_edge;
    edge_t smp2_edge;
    logic  smp_en;

    vote_state_e state_q, state_d;
    logic [2:0]  smp_q,   smp_d;
    logic        sampled_q, sampled_d;
    logic        valid_q,   valid_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.RX_IN};
        end
    end

    assign rx_sync = sync_q[SYNC_STAGES-1];

    edge_bit_counter u_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .prescale_i (bus.Prescale),
        .enable_i   (bus.enable),
        .edge_cnt_o (edge_cnt),
        .bit_cnt_o  (bit_cnt),
        .ps_o       (ps)
    );

    assign mid       = mid_sample(ps);
    assign smp0_edge = mid - edge_t'(1);
    assign smp2_edge = mid + edge_t'(1);
    assign smp_en    = bus.enable & bus.data_samp_en;

    // Progress through s0/s1/s2 is tracked so a dropped enable discards a partial set.
    always_comb begin
        state_d   = state_q;
        smp_d     = smp_q;
        sampled_d = sampled_q;
        valid_d   = 1'b0;
        if (!smp_en) begin
            state_d = VOTE_WAIT;
        end else begin
            case (state_q)
                VOTE_WAIT: begin
                    if (edge_cnt == smp0_edge) begin
                        smp_d[0] = rx_sync;
                        state_d  = VOTE_S0;
                    end
                end
                VOTE_S0: begin
                    if (edge_cnt == mid) begin
                        smp_d[1] = rx_sync;
                        state_d  = VOTE_S1;
                    end
                end
                VOTE_S1: begin
                    if (edge_cnt == smp2_edge) begin
                        smp_d[2]  = rx_sync;
                        sampled_d = majority3({rx_sync, smp_q[1], smp_q[0]});
                        valid_d   = 1'b1;
                        state_d   = VOTE_WAIT;
                    end
                end
                default: state_d = VOTE_WAIT;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= VOTE_WAIT;
            smp_q     <= 3'b111;
            sampled_q <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_q     <= smp_d;
            sampled_q <= sampled_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.RX_SYNC      = rx_sync;
    assign bus.edge_cnt     = edge_cnt;
    assign bus.bit_cnt      = bit_cnt;
    assign bus.sampled_bit  = sampled_q;
    assign bus.sample_valid = valid_q;

endmodule
